// File: rtl/mips_defs.sv
// Opcode, funct and shifter encodings shared by decode, ALU, GPR and memory.
package mips_defs;

  localparam logic [5:0] INST_R       = 6'h00;
  localparam logic [5:0] INST_J_J     = 6'h02;
  localparam logic [5:0] INST_J_JAL   = 6'h03;
  localparam logic [5:0] INST_I_BEQ   = 6'h04;
  localparam logic [5:0] INST_I_BNE   = 6'h05;
  localparam logic [5:0] INST_I_ADDI  = 6'h08;
  localparam logic [5:0] INST_I_ADDIU = 6'h09;
  localparam logic [5:0] INST_I_SLTI  = 6'h0A;
  localparam logic [5:0] INST_I_SLTIU = 6'h0B;
  localparam logic [5:0] INST_I_ANDI  = 6'h0C;
  localparam logic [5:0] INST_I_ORI   = 6'h0D;
  localparam logic [5:0] INST_I_XORI  = 6'h0E;
  localparam logic [5:0] INST_I_LUI   = 6'h0F;
  localparam logic [5:0] INST_I_LW    = 6'h23;
  localparam logic [5:0] INST_I_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_JALR = 6'h09;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    SHIFT_LL = 2'b00,
    SHIFT_RL = 2'b10,
    SHIFT_RA = 2'b11
  } shift_op_t;

endpackage

// File: rtl/mips_shifter.sv
// Combinational 32-bit barrel shifter: left, logical right, arithmetic right.
module mips_shifter
  import mips_defs::*;
(
  input  logic [31:0] data,
  input  logic [4:0]  amount,
  input  shift_op_t   op,
  output logic [31:0] result
);

  always_comb begin
    result = data << amount;
    case (op)
      SHIFT_RL: result = data >> amount;
      SHIFT_RA: result = $unsigned($signed(data) >>> amount);
      default:  result = data << amount;
    endcase
  end

endmodule

// File: rtl/mips_alu.sv
// Execute-stage ALU: decodes opcode/funct and registers one 32-bit result per cycle.
module mips_alu
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [31:0] rrs,
  input  logic [31:0] rrt_in,
  input  logic [15:0] imm,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt_in,
  output logic [31:0] rslt
);

  logic [31:0] sext;
  logic [31:0] zext;
  logic [31:0] shift_out;
  logic [4:0]  shift_amt;
  shift_op_t   shift_op;
  logic [31:0] rslt_next;
  logic [31:0] rslt_reg;

  assign sext = {{16{imm[15]}}, imm};
  assign zext = {16'b0, imm};

  // funct[2] picks the variable-amount forms; funct[1:0] encodes direction/sign.
  assign shift_amt = funct[2] ? rrs[4:0] : shamt_in;

  always_comb begin
    shift_op = SHIFT_LL;
    case (funct[1:0])
      2'b10:   shift_op = SHIFT_RL;
      2'b11:   shift_op = SHIFT_RA;
      default: shift_op = SHIFT_LL;
    endcase
  end

  mips_shifter u_shifter (
    .data   (rrt_in),
    .amount (shift_amt),
    .op     (shift_op),
    .result (shift_out)
  );

  always_comb begin
    rslt_next = '0;
    case (opcode)
      INST_R: begin
        case (funct)
          FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
          FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: rslt_next = shift_out;
          FUNCT_ADD, FUNCT_ADDU: rslt_next = rrs + rrt_in;
          FUNCT_SUB, FUNCT_SUBU: rslt_next = rrs - rrt_in;
          FUNCT_AND:  rslt_next = rrs & rrt_in;
          FUNCT_OR:   rslt_next = rrs | rrt_in;
          FUNCT_XOR:  rslt_next = rrs ^ rrt_in;
          FUNCT_NOR:  rslt_next = ~(rrs | rrt_in);
          FUNCT_SLT:  rslt_next = {31'b0, $signed(rrs) < $signed(rrt_in)};
          FUNCT_SLTU: rslt_next = {31'b0, rrs < rrt_in};
          FUNCT_JR, FUNCT_JALR: rslt_next = '0;
          default:    rslt_next = '0;
        endcase
      end
      INST_I_ADDI, INST_I_ADDIU,
      INST_I_LW, INST_I_SW: rslt_next = rrs + sext;
      INST_I_SLTI:  rslt_next = {31'b0, $signed(rrs) < $signed(sext)};
      INST_I_SLTIU: rslt_next = {31'b0, rrs < sext};
      INST_I_ANDI:  rslt_next = rrs & zext;
      INST_I_ORI:   rslt_next = rrs | zext;
      INST_I_XORI:  rslt_next = rrs ^ zext;
      INST_I_LUI:   rslt_next = {imm, 16'b0};
      // Branch/jump decisions live in the parent; nothing to produce here.
      INST_I_BEQ, INST_I_BNE, INST_J_J, INST_J_JAL: rslt_next = '0;
      default:      rslt_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) rslt_reg <= '0;
    else     rslt_reg <= rslt_next;
  end

  assign rslt = rslt_reg;

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu: directed vectors, expected results queued at issue.
module tb_mips_alu;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic [31:0] rrs;
  logic [31:0] rrt_in;
  logic [15:0] imm;
  logic [5:0]  funct;
  logic [4:0]  shamt_in;
  logic [31:0] rslt;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } txn_t;

  txn_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] prev_exp;

  always #5 clk = ~clk;

  mips_alu dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .rrs      (rrs),
    .rrt_in   (rrt_in),
    .imm      (imm),
    .funct    (funct),
    .shamt_in (shamt_in),
    .rslt     (rslt)
  );

  // Monitor: each edge presents the result of the inputs queued before it.
  initial begin
    txn_t t;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        t = sb_q.pop_front();
        checks++;
        if (rslt !== t.exp) begin
          errors++;
          $display("FAIL %s rslt=%08h expected=%08h", t.name, rslt, t.exp);
        end else begin
          $display("ok   %s rslt=%08h", t.name, rslt);
        end
      end
    end
  end

  task automatic apply(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] im, input logic [4:0] sh,
                       input logic [31:0] exp, input string nm, input bit hold);
    txn_t t;
    @(negedge clk);
    rst = r; opcode = op; funct = fn; rrs = a; rrt_in = b; imm = im; shamt_in = sh;
    t.exp = exp; t.name = nm;
    sb_q.push_back(t);
    if (hold) begin
      #1;
      checks++;
      if (rslt !== prev_exp) begin
        errors++;
        $display("FAIL hold_%s rslt=%08h expected=%08h", nm, rslt, prev_exp);
      end
    end
    prev_exp = exp;
  endtask

  initial begin
    int budget;
    rst = 1'b1; opcode = '0; funct = '0; rrs = '0; rrt_in = '0; imm = '0; shamt_in = '0;
    prev_exp = '0;

    apply(1, INST_I_ADDIU, 6'h00, 32'd5, 32'd0, 16'd3, 5'd0, 32'h0, "reset0", 0);
    apply(1, INST_I_ADDIU, 6'h00, 32'd5, 32'd0, 16'd3, 5'd0, 32'h0, "reset1", 0);
    apply(0, INST_I_ADDIU, 6'h00, 32'd5, 32'd0, 16'd3, 5'd0, 32'h8, "addiu_after_rst", 0);

    apply(0, INST_R, FUNCT_ADD,  32'h7FFFFFFF, 32'h1, 16'h0, 5'd0, 32'h80000000, "add_wrap", 0);
    apply(0, INST_R, FUNCT_SUB,  32'h0, 32'h1, 16'h0, 5'd0, 32'hFFFFFFFF, "sub_wrap", 0);
    apply(0, INST_R, FUNCT_SLT,  32'hFFFFFFFF, 32'h1, 16'h0, 5'd0, 32'h1, "slt", 0);
    apply(0, INST_R, FUNCT_SLTU, 32'hFFFFFFFF, 32'h1, 16'h0, 5'd0, 32'h0, "sltu", 0);
    apply(0, INST_R, FUNCT_AND,  32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 5'd0, 32'hF000F000, "and", 0);
    apply(0, INST_R, FUNCT_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 16'h0, 5'd0, 32'h0FF00FF0, "xor", 0);
    apply(0, INST_R, FUNCT_NOR,  32'h0, 32'h0, 16'h0, 5'd0, 32'hFFFFFFFF, "nor", 0);
    apply(0, INST_R, FUNCT_JR,   32'h1234, 32'h5678, 16'h0, 5'd0, 32'h0, "jr_zero", 0);

    apply(0, INST_I_ANDI, 6'h00, 32'h0000F0F0, 32'h0, 16'hFF00, 5'd0, 32'h0000F000, "andi", 0);
    apply(0, INST_I_ORI,  6'h00, 32'h0000F0F0, 32'h0, 16'hFF00, 5'd0, 32'h0000FFF0, "ori", 0);
    apply(0, INST_I_XORI, 6'h00, 32'h0000F0F0, 32'h0, 16'hFF00, 5'd0, 32'h00000FF0, "xori", 0);
    apply(0, INST_I_LUI,  6'h00, 32'h0000F0F0, 32'h0, 16'hFF00, 5'd0, 32'hFF000000, "lui", 0);
    apply(0, INST_I_SLTI,  6'h00, 32'h1, 32'h0, 16'hFFFF, 5'd0, 32'h0, "slti", 0);
    apply(0, INST_I_SLTIU, 6'h00, 32'h1, 32'h0, 16'hFFFF, 5'd0, 32'h1, "sltiu", 0);

    apply(0, INST_R, FUNCT_SLL,  32'h0, 32'h80000001, 16'h0, 5'd4, 32'h00000010, "sll4", 0);
    apply(0, INST_R, FUNCT_SRL,  32'h0, 32'h80000001, 16'h0, 5'd4, 32'h08000000, "srl4", 0);
    apply(0, INST_R, FUNCT_SRA,  32'h0, 32'h80000001, 16'h0, 5'd4, 32'hF8000000, "sra4", 0);
    apply(0, INST_R, FUNCT_SRAV, 32'd31, 32'h80000001, 16'h0, 5'd0, 32'hFFFFFFFF, "srav31", 0);
    apply(0, INST_R, FUNCT_SLLV, 32'd8, 32'h80000001, 16'h0, 5'd4, 32'h00000100, "sllv8", 0);
    apply(0, INST_R, FUNCT_SRLV, 32'd31, 32'h80000001, 16'h0, 5'd0, 32'h00000001, "srlv31", 0);
    apply(0, INST_R, FUNCT_SRL,  32'h0, 32'h80000001, 16'h0, 5'd0, 32'h80000001, "srl0", 0);

    apply(0, INST_I_LW, 6'h00, 32'h100, 32'h0, 16'hFFFC, 5'd0, 32'h000000FC, "lw_addr", 0);
    apply(0, INST_I_SW, 6'h00, 32'h10,  32'h0, 16'h0008, 5'd0, 32'h00000018, "sw_addr", 0);

    apply(0, INST_I_ADDI, 6'h00, 32'h10, 32'h0, 16'd1, 5'd0, 32'h11, "pipe_addi1", 1);
    apply(0, INST_I_ADDI, 6'h00, 32'h10, 32'h0, 16'd2, 5'd0, 32'h12, "pipe_addi2", 1);
    apply(0, INST_I_BEQ,  6'h00, 32'h10, 32'h10, 16'd2, 5'd0, 32'h0, "pipe_beq", 1);
    apply(0, INST_J_J,    6'h00, 32'h10, 32'h10, 16'd2, 5'd0, 32'h0, "pipe_j", 1);

    budget = 0;
    while (sb_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- Execute-stage arithmetic/logic unit of the 5-stage MIPS pipeline (IF/ID/EX/MM/WB).
- Decodes opcode/funct, combines forwarded rs/rt operands with the 16-bit immediate, and registers one 32-bit result.
- The registered result is the MM-stage value. The parent uses it as the data-memory address, the EX/ID forwarding source, and (one stage later) the write-back value.

Parameters:
- none (datapath fixed at 32 bits)

Ports:
- clk       input   1   clock, all state on rising edge
- rst       input   1   synchronous, active-high reset
- opcode    input   6   instruction bits [31:26]
- rrs       input   32  rs operand, already forwarded
- rrt_in    input   32  rt operand, already forwarded
- imm       input   16  instruction bits [15:0]
- funct     input   6   instruction bits [5:0], used when opcode==R
- shamt_in  input   5   instruction bits [10:6]
- rslt      output  32  registered result

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high (rst).
- Latency: exactly 1 cycle. rslt at edge N+1 is computed from the inputs sampled at edge N. No combinational path from inputs to rslt; this is mandatory because the parent feeds rslt back into rrs/rrt_in.
- Reset: rst=1 at an edge sets rslt=0. Reset takes priority over any operation.
- No valid/handshake. The unit computes every cycle; the parent gates side effects with its own valid bits.
- Immediates: sext = {{16{imm[15]}},imm}; zext = {16'b0,imm}.
- All add/sub wrap modulo 2^32. No overflow trap; ADD/ADDU and SUB/SUBU are identical.
- opcode 0x00 (R), selected by funct:
  - SLL 0x00: rrt_in << shamt_in
  - SRL 0x02: logical rrt_in >> shamt_in
  - SRA 0x03: arithmetic rrt_in >>> shamt_in
  - SLLV 0x04 / SRLV 0x06 / SRAV 0x07: shift amount = rrs[4:0]
  - ADD 0x20 / ADDU 0x21: rrs+rrt_in
  - SUB 0x22 / SUBU 0x23: rrs-rrt_in
  - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27: bitwise ops
  - SLT 0x2A: signed rrs<rrt_in ? 1 : 0
  - SLTU 0x2B: unsigned rrs<rrt_in ? 1 : 0
  - JR 0x08 and any other funct: 0
- I-type by opcode:
  - ADDI 0x08 / ADDIU 0x09: rrs+sext
  - SLTI 0x0A: signed compare against sext
  - SLTIU 0x0B: unsigned compare against sext
  - ANDI 0x0C / ORI 0x0D / XORI 0x0E: use zext
  - LUI 0x0F: {imm,16'b0}
  - LW 0x23 / SW 0x2B: rrs+sext (byte address; parent uses bits [31:2])
- BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03, any other opcode: 0. Branch decisions are made in the parent from the operands, not from rslt.
- Shift by 0 returns rrt_in unchanged. SRA/SRAV of a negative value by 31 yields 0xFFFFFFFF.
- Back-to-back dependent ops are supported: each cycle's result depends only on that cycle's inputs.

Decomposition:
- Shared package `mips_defs` holds:
  - opcode constants: INST_R, INST_J_J, INST_J_JAL, INST_I_BEQ, INST_I_BNE, INST_I_ADDI, INST_I_ADDIU, INST_I_SLTI, INST_I_SLTIU, INST_I_ANDI, INST_I_ORI, INST_I_XORI, INST_I_LUI, INST_I_LW, INST_I_SW
  - funct constants: FUNCT_SLL…FUNCT_SLTU, FUNCT_JR, FUNCT_JALR
- These constants are shared with the processor decode, the register file (mips_gpr) and the memory (mips_mem).
- One sub-module is natural: mips_shifter, combinational, 32-bit, left/logical-right/arithmetic-right, 5-bit amount.

Test Plan:
- Reset: rst=1 for 2 cycles with ADDIU rrs=5 imm=3 applied -> rslt=0. First edge after release -> rslt=8.
- R arithmetic/compare with rrs=0x7FFFFFFF, rrt_in=1:
  - ADD -> 0x80000000 (no trap)
  - SUB with rrs=0, rrt_in=1 -> 0xFFFFFFFF
  - SLT with rrs=0xFFFFFFFF, rrt_in=1 -> 1
  - SLTU with the same operands -> 0
- Logic/immediates with rrs=0x0000F0F0, imm=0xFF00:
  - ANDI -> 0x0000F000
  - ORI -> 0x0000FFF0
  - XORI -> 0x00000FF0
  - LUI -> 0xFF000000
  - NOR with rrs=0, rrt_in=0 -> 0xFFFFFFFF
- Shifts with rrt_in=0x80000001:
  - SLL shamt=4 -> 0x00000010
  - SRL shamt=4 -> 0x08000000
  - SRA shamt=4 -> 0xF8000000
  - SRAV with rrs=31 -> 0xFFFFFFFF
- Address/sign-extend: LW with rrs=0x100, imm=0xFFFC -> 0x000000FC. SW with rrs=0x10, imm=0x0008 -> 0x18.
- Latency/pipelining: change inputs every cycle (ADDI 1, ADDI 2, BEQ, J). rslt follows one cycle later: 1+rrs, 2+rrs, 0, 0. No input-to-output combinational change mid-cycle.
